// File: rtl/ahb_decoder.sv
// AHB-Lite address decoder and response multiplexer for four slaves.
// Unmapped active transfers get a two-cycle ERROR from an internal default slave.
module ahb_decoder #(
    parameter logic [31:0] BASE0 = 32'h0000_0000,
    parameter logic [31:0] MASK0 = 32'hFFFF_0000,
    parameter logic [31:0] BASE1 = 32'h2000_0000,
    parameter logic [31:0] MASK1 = 32'hFFFF_0000,
    parameter logic [31:0] BASE2 = 32'h4000_0000,
    parameter logic [31:0] MASK2 = 32'hFFFF_F000,
    parameter logic [31:0] BASE3 = 32'h4000_1000,
    parameter logic [31:0] MASK3 = 32'hFFFF_F000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HREADYOUT0,
    input  logic        HREADYOUT1,
    input  logic        HREADYOUT2,
    input  logic        HREADYOUT3,
    input  logic        HRESP0,
    input  logic        HRESP1,
    input  logic        HRESP2,
    input  logic        HRESP3,
    output logic [3:0]  HSEL,
    output logic [3:0]  HSEL_DP,
    output logic        HREADY,
    output logic        HRESP,
    output logic [1:0]  ds_state
);

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

    ds_state_t state_q, state_d;
    logic      ds_ready;
    logic      ds_resp;
    logic      active;
    logic      unused_htrans;

    // HTRANS[0] only separates NONSEQ/SEQ and IDLE/BUSY; activity is bit 1.
    assign active        = HTRANS[1];
    assign unused_htrans = &{1'b0, HTRANS[0]};

    // Lowest index wins on overlap, keeping HSEL one-hot or zero.
    always_comb begin
        HSEL = 4'b0000;
        if ((HADDR & MASK0) == BASE0)      HSEL = 4'b0001;
        else if ((HADDR & MASK1) == BASE1) HSEL = 4'b0010;
        else if ((HADDR & MASK2) == BASE2) HSEL = 4'b0100;
        else if ((HADDR & MASK3) == BASE3) HSEL = 4'b1000;
    end

    // Handshake: an address phase is accepted on a rising HCLK where HREADY=1;
    // while HREADY=0 the current data phase is extended and nothing new is taken.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HSEL_DP <= 4'b0000;
            state_q <= DS_IDLE;
        end else begin
            if (HREADY) HSEL_DP <= HSEL;
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ds_ready = 1'b1;
        ds_resp  = 1'b0;
        case (state_q)
            DS_IDLE: begin
                if (HREADY && HSEL == 4'b0000 && active) state_d = DS_ERR1;
            end
            DS_ERR1: begin
                ds_ready = 1'b0;
                ds_resp  = 1'b1;
                state_d  = DS_ERR2;
            end
            DS_ERR2: begin
                ds_resp = 1'b1;
                if (HSEL == 4'b0000 && active) state_d = DS_ERR1;
                else                           state_d = DS_IDLE;
            end
            default: state_d = DS_IDLE;
        endcase
    end

    always_comb begin
        HREADY = ds_ready;
        HRESP  = ds_resp;
        if (HSEL_DP[0]) begin
            HREADY = HREADYOUT0;
            HRESP  = HRESP0;
        end else if (HSEL_DP[1]) begin
            HREADY = HREADYOUT1;
            HRESP  = HRESP1;
        end else if (HSEL_DP[2]) begin
            HREADY = HREADYOUT2;
            HRESP  = HRESP2;
        end else if (HSEL_DP[3]) begin
            HREADY = HREADYOUT3;
            HRESP  = HRESP3;
        end
    end

    assign ds_state = state_q;

endmodule

// File: tb/tb_ahb_decoder.sv
// Directed bench for ahb_decoder: decode, wait states, default-slave errors, reset.
module tb_ahb_decoder;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        ro0, ro1, ro2, ro3;
    logic        rs0, rs1, rs2, rs3;
    logic [3:0]  hsel, hsel_dp, hsel_o, hsel_dp_o;
    logic        hready, hresp, hready_o, hresp_o;
    logic [1:0]  ds_state, ds_state_o;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [1:0] T_IDLE = 2'b00, T_NSEQ = 2'b10, T_SEQ = 2'b11;

    always #5 HCLK = ~HCLK;

    ahb_decoder u_dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
        .HREADYOUT0(ro0), .HREADYOUT1(ro1), .HREADYOUT2(ro2), .HREADYOUT3(ro3),
        .HRESP0(rs0), .HRESP1(rs1), .HRESP2(rs2), .HRESP3(rs3),
        .HSEL(hsel), .HSEL_DP(hsel_dp), .HREADY(hready), .HRESP(hresp),
        .ds_state(ds_state)
    );

    // Slave 3 aliased onto slave 2's window to exercise priority.
    ahb_decoder #(.BASE3(32'h4000_0000), .MASK3(32'hFFFF_F000)) u_ovl (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
        .HREADYOUT0(ro0), .HREADYOUT1(ro1), .HREADYOUT2(ro2), .HREADYOUT3(ro3),
        .HRESP0(rs0), .HRESP1(rs1), .HRESP2(rs2), .HRESP3(rs3),
        .HSEL(hsel_o), .HSEL_DP(hsel_dp_o), .HREADY(hready_o), .HRESP(hresp_o),
        .ds_state(ds_state_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic check_rsp(input string tag, input logic [3:0] dp, input logic rdy, input logic rsp);
        check_eq({tag, ".hsel_dp"}, 32'(hsel_dp), 32'(dp));
        check_eq({tag, ".hready"}, 32'(hready), 32'(rdy));
        check_eq({tag, ".hresp"}, 32'(hresp), 32'(rsp));
    endtask

    initial begin
        {ro0, ro1, ro2, ro3} = 4'b1111;
        {rs0, rs1, rs2, rs3} = 4'b0000;
        HRESETn = 1'b0;
        HTRANS  = T_NSEQ;
        HADDR   = 32'h9000_0000;
        step();
        step();

        // Reset holds an unmapped active request harmless
        check_eq("rst.hsel", 32'(hsel), 32'h0);
        check_rsp("rst", 4'b0000, 1'b1, 1'b0);
        check_eq("rst.state", 32'(ds_state), 32'd0);
        HRESETn = 1'b1;
        #1;
        check_rsp("rel", 4'b0000, 1'b1, 1'b0);
        HTRANS = T_IDLE;
        step();
        check_rsp("rel_idle", 4'b0000, 1'b1, 1'b0);

        // Mapped read to slave 1 with two wait states; pipelined address stalls
        HADDR  = 32'h2000_0010;
        HTRANS = T_NSEQ;
        #1;
        check_eq("ram.hsel", 32'(hsel), 32'h2);
        step();
        HADDR  = 32'h4000_1000;
        HTRANS = T_NSEQ;
        ro1    = 1'b0;
        #1;
        check_eq("pipe.hsel", 32'(hsel), 32'h8);
        check_rsp("ram.w1", 4'b0010, 1'b0, 1'b0);
        step();
        check_rsp("ram.w2", 4'b0010, 1'b0, 1'b0);
        ro1 = 1'b1;
        #1;
        check_rsp("ram.done", 4'b0010, 1'b1, 1'b0);
        step();
        HTRANS = T_IDLE;
        HADDR  = 32'h9000_0000;
        rs3    = 1'b0;
        #1;
        check_rsp("tmr.dp", 4'b1000, 1'b1, 1'b0);
        step();
        check_rsp("idle_unmap", 4'b0000, 1'b1, 1'b0);

        // Slave error passes through the mux
        HADDR  = 32'h4000_0040;
        HTRANS = T_NSEQ;
        step();
        HADDR  = 32'h9000_0000;
        HTRANS = T_IDLE;
        rs2    = 1'b1;
        #1;
        check_rsp("gpio.err", 4'b0100, 1'b1, 1'b1);
        step();
        rs2 = 1'b0;

        // Unmapped active: ERR1 then ERR2 then IDLE
        HTRANS = T_NSEQ;
        step();
        HTRANS = T_IDLE;
        #1;
        check_rsp("un.err1", 4'b0000, 1'b0, 1'b1);
        check_eq("un.state1", 32'(ds_state), 32'd1);
        step();
        check_rsp("un.err2", 4'b0000, 1'b1, 1'b1);
        check_eq("un.state2", 32'(ds_state), 32'd2);
        step();
        check_rsp("un.idle", 4'b0000, 1'b1, 1'b0);

        // Back-to-back unmapped transfers, no OKAY gap between errors
        HTRANS = T_NSEQ;
        step();
        HTRANS = T_SEQ;
        HADDR  = 32'h9000_0004;
        #1;
        check_rsp("b2b.a1", 4'b0000, 1'b0, 1'b1);
        step();
        check_rsp("b2b.a2", 4'b0000, 1'b1, 1'b1);
        step();
        HTRANS = T_IDLE;
        #1;
        check_rsp("b2b.b1", 4'b0000, 1'b0, 1'b1);
        step();
        check_rsp("b2b.b2", 4'b0000, 1'b1, 1'b1);
        step();
        check_rsp("b2b.ok", 4'b0000, 1'b1, 1'b0);
        step();
        check_rsp("b2b.ok2", 4'b0000, 1'b1, 1'b0);

        // Mapped transfer presented in ERR2 is accepted that cycle
        HTRANS = T_NSEQ;
        step();
        HADDR = 32'h0000_0100;
        #1;
        check_rsp("e2m.err1", 4'b0000, 1'b0, 1'b1);
        step();
        check_rsp("e2m.err2", 4'b0000, 1'b1, 1'b1);
        step();
        HTRANS = T_IDLE;
        #1;
        check_rsp("e2m.rom", 4'b0001, 1'b1, 1'b0);
        check_eq("e2m.state", 32'(ds_state), 32'd0);

        // Decode boundaries and priority
        HADDR = 32'h4000_1000; #1; check_eq("bnd.tmr", 32'(hsel), 32'h8);
        HADDR = 32'h4000_2000; #1; check_eq("bnd.hole", 32'(hsel), 32'h0);
        HADDR = 32'h4000_0FFC; #1; check_eq("bnd.gpio", 32'(hsel), 32'h4);
        check_eq("ovl.gpio", 32'(hsel_o), 32'h4);
        HADDR = 32'h0000_FFFF; #1; check_eq("bnd.romtop", 32'(hsel), 32'h1);
        HADDR = 32'h0001_0000; #1; check_eq("bnd.romend", 32'(hsel), 32'h0);
        HADDR = 32'h2000_FFFC; #1; check_eq("bnd.ramtop", 32'(hsel), 32'h2);

        // Reset asserted mid-error takes effect without a clock
        HADDR  = 32'h9000_0000;
        HTRANS = T_NSEQ;
        step();
        HTRANS = T_IDLE;
        #1;
        check_rsp("mid.err1", 4'b0000, 1'b0, 1'b1);
        HRESETn = 1'b0;
        #1;
        check_rsp("mid.rst", 4'b0000, 1'b1, 1'b0);
        check_eq("mid.state", 32'(ds_state), 32'd0);
        step();
        HRESETn = 1'b1;
        HADDR   = 32'h0000_0004;
        HTRANS  = T_NSEQ;
        #1;
        check_eq("post.hsel", 32'(hsel), 32'h1);
        step();
        HTRANS = T_IDLE;
        #1;
        check_rsp("post.rom", 4'b0001, 1'b1, 1'b0);

        // Reset during a slave wait state
        HTRANS = T_NSEQ;
        HADDR  = 32'h2000_0000;
        step();
        ro1    = 1'b0;
        HTRANS = T_IDLE;
        #1;
        check_rsp("ws.wait", 4'b0010, 1'b0, 1'b0);
        HRESETn = 1'b0;
        #1;
        check_rsp("ws.rst", 4'b0000, 1'b1, 1'b0);
        ro1 = 1'b1;
        step();
        HRESETn = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
